seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Watches a scanned segment/digit-select bus (led/sele) and reconstructs the 4-digit hex value and decimal points being shown.
- Rejects ghosting and transients, flags segment patterns it cannot decode, and reports when scanning has stopped.
- Used for display loopback self-check and for driving readback registers from an externally scanned display.

Parameters:
- SETTLE, 4: consecutive sampled cycles a (led, sele) pair must hold before it is accepted; must be at least 1.
- TIMEOUT, 32'h003f_0000: cycles without an accept before stale asserts.

Ports:
- clkIn  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- led  input  8  segment bus, active-low; bit0=a … bit6=g, bit7=dp
- sele  input  4  digit select, active-low one-hot; 1110=digit0 … 0111=digit3
- value  output  16  decoded digits; digit i occupies [4i+3:4i]
- dp  output  4  decimal point per digit, 1 = lit
- frame_vld  output  1  one-cycle pulse when value/dp update
- seg_err  output  1  one-cycle pulse when an accepted pattern is not a hex glyph
- stale  output  1  level, asserted when no accept has occurred for TIMEOUT cycles

Behaviour:
- Reset, async on rst high:
  - value=0, dp=0, frame_vld=0, seg_err=0, stale=0.
  - Digit buffers, seen[3:0], stability counter and timeout counter all cleared.
  - FSM goes to IDLE.
- Input sampling:
  - led and sele are registered every cycle into led_q and sele_q.
  - stab_cnt clears to 0 whenever {led_q, sele_q} changes; otherwise it increments, saturating at SETTLE-1.
- FSM states:
  - IDLE: sele_q is not a valid one-hot (1111 blank, or two or more bits low). Move to SETTLE once sele_q is valid.
  - SETTLE: wait for the pair to stabilise. When stab_cnt==SETTLE-1, perform an accept and move to HELD. Any pair change restarts the count; if sele_q is invalid, go to IDLE.
  - HELD: ignore the pair until it changes, then go to SETTLE (valid sele_q) or IDLE (invalid sele_q). Only one accept is allowed per dwell.
- Accept of digit i, all outputs registered:
  - led_q[6:0] is matched against the hex glyph table. Bit7 is excluded from the match.
  - Hit: buf[i] <= nibble, dpbuf[i] <= ~led_q[7], seen[i] <= 1.
  - Miss: seg_err pulses for 1 cycle; buf and seen are unchanged.
  - Re-accepting a digit before the frame completes overwrites buf[i].
- Frame completion:
  - When seen, including the current hit, equals 1111, load value from the buffers (current digit taken from the fresh nibble) and dp from dpbuf.
  - frame_vld pulses for 1 cycle and seen clears to 0000 in the same cycle.
- Latency: if the pair is applied before clock edge k and held, value/frame_vld update at edge k+SETTLE+1.
- Timeout:
  - to_cnt counts every cycle and clears on any accept, whether hit or miss.
  - stale is set when to_cnt reaches TIMEOUT-1; to_cnt then saturates and stale holds.
  - stale clears on the next accept.
  - If an accept and the timeout occur in the same cycle, the accept wins: stale=0.
- Reset mid-frame: partial seen and buffers are discarded; a full set of 4 new digit accepts is required before the next frame_vld.
- Width rules:
  - value is unsigned and concatenated as {buf3, buf2, buf1, buf0}.
  - stab_cnt is $clog2(SETTLE)+1 bits; to_cnt is 32 bits.

Decomposition:
- Shared package (disp_pkg):
  - Segment glyph constants SEG_0..SEG_F, active-low, with bit7 set: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - Select constants SEL_D0..SEL_D3.
  - FSM state typedef {IDLE, SETTLE, HELD}.
- Sub-module seg7_to_hex: combinational glyph lookup.
  - Input: 7-bit pattern.
  - Outputs: 4-bit nibble and hit flag.
  - The display driver's encoder reuses the same package constants.

Test Plan (SETTLE=4, TIMEOUT=64):
- Reset: assert rst mid-cycle -> all outputs 0 immediately, without waiting for clkIn.
- Full frame: hold each pair for 8 cycles, in order (1110, 90), (1101, C0), (1011, F9), (0111, A4) -> value=16'h2109, dp=0000, one frame_vld pulse 5 edges after the last pair is applied; seg_err never pulses.
- Glitch reject: apply (1110, 99) for 3 cycles, then (1110, C0) for 8 cycles, completing the frame with digits 1..3 = 0 -> value=16'h0000; digit 4 is never captured.
- Bad glyph: hold (1110, 6C) for 8 cycles -> exactly one seg_err pulse, seen unchanged, no frame_vld.
- Stale/invalid select: after an accept, hold sele=1100 for 100 cycles -> no accept; stale rises 64 cycles after the last accept. Then apply a valid (1110, F9) -> stale falls at the accept edge.
- Reset mid-frame: accept 3 digits, pulse rst, then accept only digit3 (0111, 8E) -> no frame_vld. After digits 0..2 = (80, 80, 80), value=16'hF888 and frame_vld pulses.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display driver and its
// scan decoder: active-low glyphs, digit selects and decoder FSM states.
package disp_pkg;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] GLYPH [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    localparam logic [3:0] SEL_D0 = 4'b1110;
    localparam logic [3:0] SEL_D1 = 4'b1101;
    localparam logic [3:0] SEL_D2 = 4'b1011;
    localparam logic [3:0] SEL_D3 = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HELD
    } state_t;

    function automatic logic sel_valid(input logic [3:0] s);
        return (s == SEL_D0) || (s == SEL_D1) ||
               (s == SEL_D2) || (s == SEL_D3);
    endfunction

    function automatic logic [1:0] sel_idx(input logic [3:0] s);
        logic [1:0] r;
        r = 2'd0;
        case (s)
            SEL_D1:  r = 2'd1;
            SEL_D2:  r = 2'd2;
            SEL_D3:  r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of a 7-segment pattern (dp excluded)
// into its hex nibble; hit_o is low for any non-glyph pattern.
module seg7_to_hex
    import disp_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       hit_o
);

    always_comb begin
        nib_o = 4'd0;
        hit_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == GLYPH[i][6:0]) begin
                nib_o = 4'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the 4-digit hex value and decimal points from a scanned
// active-low segment/digit-select bus, with settle filtering and timeout.
module seg_scan_decoder
    import disp_pkg::*;
#(
    parameter int          SETTLE  = 4,
    parameter logic [31:0] TIMEOUT = 32'h003f_0000
) (
    input  logic        clkIn,
    input  logic        rst,
    input  logic [7:0]  led,
    input  logic [3:0]  sele,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        frame_vld,
    output logic        seg_err,
    output logic        stale
);

    localparam int          SW       = $clog2(SETTLE) + 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE - 1);
    localparam logic [31:0] TO_MAX   = TIMEOUT - 32'd1;

    logic [7:0]    led_q, led_p;
    logic [3:0]    sele_q, sele_p;
    logic [SW-1:0] stab_q, stab_d;
    logic [31:0]   to_q;
    state_t        state_q;
    logic [3:0]    dig_q [4];
    logic [3:0]    dpb_q;
    logic [3:0]    seen_q;

    logic          chg;
    logic          vld;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          hit;
    logic          accept;
    logic [3:0]    seen_d;
    logic [15:0]   value_d;
    logic [3:0]    dp_d;

    seg7_to_hex u_lut (
        .seg_i (led_q[6:0]),
        .nib_o (nib),
        .hit_o (hit)
    );

    // led_p/sele_p hold the previous sample so a change is seen one
    // cycle after it lands in led_q/sele_q.
    always_comb begin
        chg    = {led_q, sele_q} != {led_p, sele_p};
        vld    = sel_valid(sele_q);
        idx    = sel_idx(sele_q);
        stab_d = stab_q;
        if (chg)
            stab_d = '0;
        else if (stab_q != STAB_MAX)
            stab_d = stab_q + 1'b1;
        accept = (state_q == S_SETTLE) && vld && !chg &&
                 (stab_q == STAB_MAX);
        seen_d = seen_q | (4'b0001 << idx);
        for (int i = 0; i < 4; i++) begin
            value_d[4*i +: 4] = (2'(i) == idx) ? nib : dig_q[i];
            dp_d[i]           = (2'(i) == idx) ? ~led_q[7] : dpb_q[i];
        end
    end

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            led_q     <= 8'hFF;
            led_p     <= 8'hFF;
            sele_q    <= 4'hF;
            sele_p    <= 4'hF;
            stab_q    <= '0;
            to_q      <= '0;
            state_q   <= S_IDLE;
            dpb_q     <= '0;
            seen_q    <= '0;
            value     <= '0;
            dp        <= '0;
            frame_vld <= 1'b0;
            seg_err   <= 1'b0;
            stale     <= 1'b0;
            for (int i = 0; i < 4; i++)
                dig_q[i] <= '0;
        end else begin
            led_q     <= led;
            sele_q    <= sele;
            led_p     <= led_q;
            sele_p    <= sele_q;
            stab_q    <= stab_d;
            frame_vld <= 1'b0;
            seg_err   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (vld)
                        state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!vld)
                        state_q <= S_IDLE;
                    else if (accept)
                        state_q <= S_HELD;
                end
                S_HELD: begin
                    if (chg)
                        state_q <= vld ? S_SETTLE : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // An accept beats a simultaneous timeout.
            if (accept) begin
                to_q  <= '0;
                stale <= 1'b0;
                if (hit) begin
                    dig_q[idx] <= nib;
                    dpb_q[idx] <= ~led_q[7];
                    if (seen_d == 4'hF) begin
                        value     <= value_d;
                        dp        <= dp_d;
                        frame_vld <= 1'b1;
                        seen_q    <= '0;
                    end else begin
                        seen_q <= seen_d;
                    end
                end else begin
                    seg_err <= 1'b1;
                end
            end else if (to_q == TO_MAX) begin
                stale <= 1'b1;
            end else begin
                to_q <= to_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder with SETTLE=4, TIMEOUT=64.
module tb_seg_scan_decoder;

    logic        clkIn = 1'b0;
    logic        rst   = 1'b0;
    logic [7:0]  led   = 8'hFF;
    logic [3:0]  sele  = 4'hF;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        frame_vld;
    logic        seg_err;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int frames = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          c;
        logic [15:0] v;
        logic [3:0]  d;
    } frm_t;

    frm_t fq[$];
    int   sq[$];

    seg_scan_decoder #(
        .SETTLE  (4),
        .TIMEOUT (32'd64)
    ) dut (
        .clkIn     (clkIn),
        .rst       (rst),
        .led       (led),
        .sele      (sele),
        .value     (value),
        .dp        (dp),
        .frame_vld (frame_vld),
        .seg_err   (seg_err),
        .stale     (stale)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop expected events as the DUT produces them.
    always @(negedge clkIn) begin
        if (mon_en && frame_vld) begin
            frames++;
            chk("frame_expected", 32'(fq.size() > 0), 32'd1);
            if (fq.size() > 0) begin
                frm_t e;
                e = fq.pop_front();
                chk("frame_cycle", 32'(cyc), 32'(e.c));
                chk("frame_value", 32'(value), 32'(e.v));
                chk("frame_dp", 32'(dp), 32'(e.d));
            end
        end
        if (mon_en && seg_err) begin
            chk("seg_err_expected", 32'(sq.size() > 0), 32'd1);
            if (sq.size() > 0)
                chk("seg_err_cycle", 32'(cyc), 32'(sq.pop_front()));
        end
    end

    // Call at a negedge; returns the edge index that first samples the pair.
    task automatic apply(input logic [3:0] s, input logic [7:0] l,
                         input int n, output int k);
        sele = s;
        led  = l;
        k    = cyc + 1;
        repeat (n) @(negedge clkIn);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clkIn);
    endtask

    task automatic push_frame(input int c, input logic [15:0] v,
                              input logic [3:0] d);
        frm_t e;
        e.c = c;
        e.v = v;
        e.d = d;
        fq.push_back(e);
    endtask

    initial begin
        int k;
        int a;

        repeat (2) @(negedge clkIn);
        #2 rst = 1'b1;
        #1;
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_dp", 32'(dp), 32'd0);
        chk("rst_frame_vld", 32'(frame_vld), 32'd0);
        chk("rst_seg_err", 32'(seg_err), 32'd0);
        chk("rst_stale", 32'(stale), 32'd0);
        @(negedge clkIn);
        rst    = 1'b0;
        mon_en = 1'b1;

        apply(4'b1110, 8'h90, 8, k);
        apply(4'b1101, 8'hC0, 8, k);
        apply(4'b1011, 8'hF9, 8, k);
        push_frame(cyc + 6, 16'h2109, 4'b0000);
        apply(4'b0111, 8'hA4, 8, k);

        apply(4'b1110, 8'h99, 3, k);
        apply(4'b1110, 8'hC0, 8, k);
        apply(4'b1101, 8'hC0, 8, k);
        apply(4'b1011, 8'hC0, 8, k);
        push_frame(cyc + 6, 16'h0000, 4'b0000);
        apply(4'b0111, 8'hC0, 8, k);

        apply(4'b1101, 8'hF9, 8, k);
        apply(4'b1011, 8'hF9, 8, k);
        apply(4'b0111, 8'hF9, 8, k);
        sq.push_back(cyc + 6);
        apply(4'b1110, 8'h6C, 8, k);
        push_frame(cyc + 6, 16'h1111, 4'b0001);
        apply(4'b1110, 8'h79, 8, k);
        a = k + 5;

        sele = 4'b1100;
        led  = 8'hFF;
        k    = cyc + 1;
        wait_cyc(a + 63);
        chk("stale_before", 32'(stale), 32'd0);
        wait_cyc(a + 64);
        chk("stale_rise", 32'(stale), 32'd1);
        wait_cyc(k + 99);

        sele = 4'b1110;
        led  = 8'hF9;
        k    = cyc + 1;
        wait_cyc(k + 4);
        chk("stale_hold", 32'(stale), 32'd1);
        wait_cyc(k + 5);
        chk("stale_fall", 32'(stale), 32'd0);
        wait_cyc(k + 7);

        apply(4'b1110, 8'hC0, 8, k);
        apply(4'b1101, 8'hC0, 8, k);
        apply(4'b1011, 8'hC0, 8, k);
        apply(4'b1111, 8'hFF, 3, k);
        #2 rst = 1'b1;
        #1;
        chk("midrst_value", 32'(value), 32'd0);
        chk("midrst_dp", 32'(dp), 32'd0);
        @(negedge clkIn);
        rst = 1'b0;

        apply(4'b0111, 8'h8E, 8, k);
        apply(4'b1110, 8'h80, 8, k);
        apply(4'b1101, 8'h80, 8, k);
        push_frame(cyc + 6, 16'hF888, 4'b0000);
        apply(4'b1011, 8'h80, 8, k);
        apply(4'b1111, 8'hFF, 10, k);

        chk("frames_pending", 32'(fq.size()), 32'd0);
        chk("seg_err_pending", 32'(sq.size()), 32'd0);
        chk("frame_count", 32'(frames), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
